// File: rtl/cmd_scheduler.sv
// cmd_scheduler: round-robin arbiter that shares the single SD CMD engine among
// up to four command requesters in the clk_host domain.
//
// A requester is granted in IDLE, and its index and argument are latched and
// presented to the CMD engine with new_command held high. The scheduler then
// waits for cmd_complete or a timeout. It reports the response and status back
// to the granted requester with a one-cycle done_valid pulse, then holds an
// idle gap before the next grant.
//
// Ports:
//   clk_host, reset_host    clock (rising edge), async active-high reset
//   req_valid/index/argument per-requester command requests (packed fields)
//   req_ready               one-hot pulse: request accepted
//   done_valid              one-hot pulse: request finished
//   done_response/index_error/timeout  held status of the last command
//   new_command, cmd_index, cmd_argument  drive to the CMD engine
//   cmd_complete, cmd_index_error, response  results from the CMD engine
//   busy                    scheduler not idle
//   grant_id                current or last granted requester
module cmd_scheduler #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 8
) (
    input  logic                    clk_host,
    input  logic                    reset_host,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [6*NUM_REQ-1:0]    req_index,
    input  logic [32*NUM_REQ-1:0]   req_argument,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      done_valid,
    output logic [127:0]            done_response,
    output logic                    done_index_error,
    output logic                    done_timeout,
    output logic                    new_command,
    output logic [5:0]              cmd_index,
    output logic [31:0]             cmd_argument,
    input  logic                    cmd_complete,
    input  logic                    cmd_index_error,
    input  logic [127:0]            response,
    output logic                    busy,
    output logic [1:0]              grant_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [15:0]        timer_q, timer_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               new_command_q, new_command_d;
    logic [5:0]         cmd_index_q, cmd_index_d;
    logic [31:0]        cmd_argument_q, cmd_argument_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] done_valid_q, done_valid_d;
    logic [127:0]       done_response_q, done_response_d;
    logic               done_index_error_q, done_index_error_d;
    logic               done_timeout_q, done_timeout_d;
    logic [1:0]         grant_q, grant_d;

    // Round-robin search: first pending requester after rr_ptr, wrapping.
    logic       found;
    logic [1:0] sel;
    logic [1:0] cand;
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr_q;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = 2'((int'(rr_ptr_q) + i) % NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && cand == 2'(j) && req_valid[j]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end
    end

    // Field mux and one-hot decodes for the selected and granted requesters.
    logic [5:0]         sel_index;
    logic [31:0]        sel_argument;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [NUM_REQ-1:0] grant_onehot;
    always_comb begin
        sel_index    = '0;
        sel_argument = '0;
        sel_onehot   = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == 2'(i)) begin
                sel_index    = req_index[6*i +: 6];
                sel_argument = req_argument[32*i +: 32];
                sel_onehot[i] = 1'b1;
            end
            if (grant_q == 2'(i)) begin
                grant_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        timer_d            = timer_q;
        gap_cnt_d          = gap_cnt_q;
        new_command_d      = new_command_q;
        cmd_index_d        = cmd_index_q;
        cmd_argument_d     = cmd_argument_q;
        req_ready_d        = '0;
        done_valid_d       = '0;
        done_response_d    = done_response_q;
        done_index_error_d = done_index_error_q;
        done_timeout_d     = done_timeout_q;
        grant_d            = grant_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    cmd_index_d    = sel_index;
                    cmd_argument_d = sel_argument;
                    new_command_d  = 1'b1;
                    req_ready_d    = sel_onehot;
                    grant_d        = sel;
                    rr_ptr_d       = sel;
                    timer_d        = '0;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                // Completion takes priority over a timeout on the same edge.
                if (cmd_complete || timer_q == TIMER_LAST) begin
                    new_command_d = 1'b0;
                    done_valid_d  = grant_onehot;
                    gap_cnt_d     = '0;
                    state_d       = (GAP_CYCLES == 0) ? IDLE : GAP;
                    if (cmd_complete) begin
                        done_response_d    = response;
                        done_index_error_d = cmd_index_error;
                        done_timeout_d     = 1'b0;
                    end else begin
                        done_response_d    = '0;
                        done_index_error_d = 1'b0;
                        done_timeout_d     = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_host or posedge reset_host) begin
        if (reset_host) begin
            state_q            <= IDLE;
            rr_ptr_q           <= 2'(NUM_REQ - 1);
            timer_q            <= '0;
            gap_cnt_q          <= '0;
            new_command_q      <= 1'b0;
            cmd_index_q        <= '0;
            cmd_argument_q     <= '0;
            req_ready_q        <= '0;
            done_valid_q       <= '0;
            done_response_q    <= '0;
            done_index_error_q <= 1'b0;
            done_timeout_q     <= 1'b0;
            grant_q            <= '0;
        end else begin
            state_q            <= state_d;
            rr_ptr_q           <= rr_ptr_d;
            timer_q            <= timer_d;
            gap_cnt_q          <= gap_cnt_d;
            new_command_q      <= new_command_d;
            cmd_index_q        <= cmd_index_d;
            cmd_argument_q     <= cmd_argument_d;
            req_ready_q        <= req_ready_d;
            done_valid_q       <= done_valid_d;
            done_response_q    <= done_response_d;
            done_index_error_q <= done_index_error_d;
            done_timeout_q     <= done_timeout_d;
            grant_q            <= grant_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign done_valid       = done_valid_q;
    assign done_response    = done_response_q;
    assign done_index_error = done_index_error_q;
    assign done_timeout     = done_timeout_q;
    assign new_command      = new_command_q;
    assign cmd_index        = cmd_index_q;
    assign cmd_argument     = cmd_argument_q;
    assign grant_id         = grant_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler: a table of transactions driven through one
// generic transaction task, plus hand-written reset and stray-completion cases.
module tb_cmd_scheduler;

    localparam int NR = 3;
    localparam int TO = 16;
    localparam int GC = 8;

    logic              clk_host;
    logic              reset_host;
    logic [NR-1:0]     req_valid;
    logic [6*NR-1:0]   req_index;
    logic [32*NR-1:0]  req_argument;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     done_valid;
    logic [127:0]      done_response;
    logic              done_index_error;
    logic              done_timeout;
    logic              new_command;
    logic [5:0]        cmd_index;
    logic [31:0]       cmd_argument;
    logic              cmd_complete;
    logic              cmd_index_error;
    logic [127:0]      response;
    logic              busy;
    logic [1:0]        grant_id;

    cmd_scheduler #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GC)
    ) dut (
        .clk_host         (clk_host),
        .reset_host       (reset_host),
        .req_valid        (req_valid),
        .req_index        (req_index),
        .req_argument     (req_argument),
        .req_ready        (req_ready),
        .done_valid       (done_valid),
        .done_response    (done_response),
        .done_index_error (done_index_error),
        .done_timeout     (done_timeout),
        .new_command      (new_command),
        .cmd_index        (cmd_index),
        .cmd_argument     (cmd_argument),
        .cmd_complete     (cmd_complete),
        .cmd_index_error  (cmd_index_error),
        .response         (response),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    initial clk_host = 1'b0;
    always #5 clk_host = ~clk_host;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_host);
        #1;
    endtask

    function automatic logic [5:0] exp_idx(input logic [1:0] g);
        case (g)
            2'd0:    return 6'd17;
            2'd1:    return 6'd33;
            default: return 6'd50;
        endcase
    endfunction

    function automatic logic [31:0] exp_arg(input logic [1:0] g);
        case (g)
            2'd0:    return 32'h0000_002C;
            2'd1:    return 32'hDEAD_BEEF;
            default: return 32'h1234_5678;
        endcase
    endfunction

    typedef struct {
        logic [NR-1:0] valid;
        int            lat;        // edges after grant until completion; 0 = never
        logic          err;
        logic [127:0]  resp;
        logic [NR-1:0] exp_ready;
        logic [1:0]    exp_grant;
        int            exp_high;
        logic          exp_to;
        logic          exp_err;
        logic [127:0]  exp_resp;
    } vec_t;

    vec_t vecs[8];

    task automatic run_txn(input vec_t v);
        int high;
        req_valid = v.valid;
        step();
        chk("req_ready", 128'(req_ready), 128'(v.exp_ready));
        chk("new_command_rise", 128'(new_command), 128'(1));
        chk("grant_id", 128'(grant_id), 128'(v.exp_grant));
        chk("cmd_index", 128'(cmd_index), 128'(exp_idx(v.exp_grant)));
        chk("cmd_argument", 128'(cmd_argument), 128'(exp_arg(v.exp_grant)));
        high = 1;
        for (int n = 0; n < 64; n++) begin
            if (v.lat != 0 && high == v.lat) begin
                cmd_complete    = 1'b1;
                response        = v.resp;
                cmd_index_error = v.err;
            end
            step();
            cmd_complete    = 1'b0;
            response        = '0;
            cmd_index_error = 1'b0;
            if (n == 0) chk("req_ready_pulse", 128'(req_ready), 128'(0));
            if (!new_command) break;
            high++;
            chk("cmd_index_stable", 128'(cmd_index), 128'(exp_idx(v.exp_grant)));
            chk("done_valid_wait", 128'(done_valid), 128'(0));
        end
        chk("new_command_cycles", 128'(high), 128'(v.exp_high));
        chk("done_valid", 128'(done_valid), 128'(v.exp_ready));
        chk("done_timeout", 128'(done_timeout), 128'(v.exp_to));
        chk("done_index_error", 128'(done_index_error), 128'(v.exp_err));
        chk("done_response", done_response, v.exp_resp);
        chk("busy_gap", 128'(busy), 128'(1));
        // Stray completion in GAP must be ignored.
        cmd_complete    = 1'b1;
        response        = '1;
        cmd_index_error = 1'b1;
        step();
        cmd_complete    = 1'b0;
        response        = '0;
        cmd_index_error = 1'b0;
        chk("done_valid_pulse", 128'(done_valid), 128'(0));
        chk("gap_stray_resp", done_response, v.exp_resp);
        chk("gap_stray_err", 128'(done_index_error), 128'(v.exp_err));
        for (int n = 0; n < GC - 2; n++) step();
        chk("gap_busy_last", 128'(busy), 128'(1));
        step();
        chk("gap_end_idle", 128'(busy), 128'(0));
        chk("gap_nc_low", 128'(new_command), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{valid: 3'b001, lat: 5,  err: 1'b0, resp: {16{8'hA5}},
                    exp_ready: 3'b001, exp_grant: 2'd0, exp_high: 5, exp_to: 1'b0,
                    exp_err: 1'b0, exp_resp: {16{8'hA5}}};
        vecs[1] = '{valid: 3'b111, lat: 3,  err: 1'b0, resp: {32{4'h1}},
                    exp_ready: 3'b010, exp_grant: 2'd1, exp_high: 3, exp_to: 1'b0,
                    exp_err: 1'b0, exp_resp: {32{4'h1}}};
        vecs[2] = '{valid: 3'b111, lat: 3,  err: 1'b1, resp: {32{4'h2}},
                    exp_ready: 3'b100, exp_grant: 2'd2, exp_high: 3, exp_to: 1'b0,
                    exp_err: 1'b1, exp_resp: {32{4'h2}}};
        vecs[3] = '{valid: 3'b111, lat: 3,  err: 1'b0, resp: {32{4'h3}},
                    exp_ready: 3'b001, exp_grant: 2'd0, exp_high: 3, exp_to: 1'b0,
                    exp_err: 1'b0, exp_resp: {32{4'h3}}};
        vecs[4] = '{valid: 3'b010, lat: 0,  err: 1'b1, resp: {32{4'hF}},
                    exp_ready: 3'b010, exp_grant: 2'd1, exp_high: 16, exp_to: 1'b1,
                    exp_err: 1'b0, exp_resp: 128'h0};
        vecs[5] = '{valid: 3'b100, lat: 16, err: 1'b1, resp: {16{8'h5A}},
                    exp_ready: 3'b100, exp_grant: 2'd2, exp_high: 16, exp_to: 1'b0,
                    exp_err: 1'b1, exp_resp: {16{8'h5A}}};
        vecs[6] = '{valid: 3'b101, lat: 2,  err: 1'b0, resp: 128'h6,
                    exp_ready: 3'b001, exp_grant: 2'd0, exp_high: 2, exp_to: 1'b0,
                    exp_err: 1'b0, exp_resp: 128'h6};
        vecs[7] = '{valid: 3'b101, lat: 4,  err: 1'b0, resp: 128'h7,
                    exp_ready: 3'b100, exp_grant: 2'd2, exp_high: 4, exp_to: 1'b0,
                    exp_err: 1'b0, exp_resp: 128'h7};

        reset_host      = 1'b1;
        req_valid       = '0;
        req_index       = {6'd50, 6'd33, 6'd17};
        req_argument    = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_002C};
        cmd_complete    = 1'b0;
        cmd_index_error = 1'b0;
        response        = '0;
        step();
        step();
        reset_host = 1'b0;
        step();
        chk("rst_new_command", 128'(new_command), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_done_valid", 128'(done_valid), 128'(0));
        chk("rst_done_response", done_response, 128'h0);
        chk("rst_done_flags", 128'({done_index_error, done_timeout}), 128'(0));
        chk("rst_cmd_fields", 128'({cmd_index, cmd_argument}), 128'(0));
        chk("rst_grant_busy", 128'({grant_id, busy}), 128'(0));

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);
        req_valid = '0;

        // Stray completion in IDLE.
        cmd_complete    = 1'b1;
        response        = '1;
        cmd_index_error = 1'b1;
        step();
        cmd_complete    = 1'b0;
        response        = '0;
        cmd_index_error = 1'b0;
        chk("idle_stray_done_valid", 128'(done_valid), 128'(0));
        chk("idle_stray_busy", 128'(busy), 128'(0));
        chk("idle_stray_resp", done_response, 128'h7);
        chk("idle_stray_err", 128'(done_index_error), 128'(0));
        chk("idle_stray_nc", 128'(new_command), 128'(0));

        // Reset mid-WAIT: grant req1 (rr_ptr=1), then reset 3 cycles later.
        req_valid = 3'b010;
        step();
        chk("pre_rst_grant", 128'(grant_id), 128'(1));
        req_valid = '0;
        step();
        step();
        step();
        chk("pre_rst_nc", 128'(new_command), 128'(1));
        #2 reset_host = 1'b1;
        #1;
        chk("async_rst_nc", 128'(new_command), 128'(0));
        chk("async_rst_busy", 128'(busy), 128'(0));
        chk("async_rst_grant", 128'(grant_id), 128'(0));
        chk("async_rst_resp", done_response, 128'h0);
        step();
        chk("rst_no_done_valid", 128'(done_valid), 128'(0));
        reset_host = 1'b0;
        step();
        chk("post_rst_idle", 128'(busy), 128'(0));
        // With rr_ptr back at 2 the search starts at 0, so req1 beats req2.
        req_valid = 3'b110;
        step();
        chk("post_rst_grant", 128'(grant_id), 128'(1));
        chk("post_rst_ready", 128'(req_ready), 128'(3'b010));
        chk("post_rst_index", 128'(cmd_index), 128'(6'd33));
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_scheduler.md
# cmd_scheduler

Round-robin scheduler that shares the single SD CMD engine among up to four command requesters (e.g. host register file, auto-CMD12 generator, init sequencer). It grants one requester at a time, latches its index/argument, drives the engine's `new_command`/`cmd_index`/`cmd_argument` inputs, and waits for `cmd_complete` or a timeout. It returns the 128-bit response and status to the granted requester, then enforces an idle gap before the next grant. It sits between the host-side command sources and the CMD block, in the `clk_host` domain.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters; legal range 1..4.
- `TIMEOUT_CYCLES`, default 1024: maximum `clk_host` cycles to wait for `cmd_complete`; legal range 2..65535.
- `GAP_CYCLES`, default 8: `clk_host` cycles with `new_command` low between commands; legal range 0..255.

Ports:
- `clk_host`  in  1  sole clock, rising edge.
- `reset_host`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i: requester i has a pending command.
- `req_index`  in  6*NUM_REQ  requester i's command index in bits [6i+5:6i].
- `req_argument`  in  32*NUM_REQ  requester i's argument in bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse: requester i's command accepted.
- `done_valid`  out  NUM_REQ  one-hot, one-cycle pulse: requester i's command finished.
- `done_response`  out  128  captured response; held until the next completion.
- `done_index_error`  out  1  captured `cmd_index_error`; held.
- `done_timeout`  out  1  1 when the last command timed out; held.
- `new_command`  out  1  request level to the CMD engine.
- `cmd_index`  out  6  latched index to the CMD engine.
- `cmd_argument`  out  32  latched argument to the CMD engine.
- `cmd_complete`  in  1  CMD engine completion.
- `cmd_index_error`  in  1  CMD engine error flag; valid with `cmd_complete`.
- `response`  in  128  CMD engine response; valid with `cmd_complete`.
- `busy`  out  1  1 whenever state ≠ IDLE.
- `grant_id`  out  2  index of the current or last granted requester.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: command issued to the engine.
  - GAP: enforced inter-command spacing.
- All outputs are registered except `busy`, which is decoded from the state.
- Reset: state=IDLE, `rr_ptr`=NUM_REQ-1, and all outputs 0 (`new_command`, `cmd_index`, `cmd_argument`, `req_ready`, `done_*`, `grant_id`).
- IDLE, any `req_valid` bit set:
  - Select the first set bit searching from (`rr_ptr`+1) mod NUM_REQ upward, with wrap-around.
  - On that edge: `cmd_index`/`cmd_argument` load the selected fields; `new_command`<=1; `req_ready`<=onehot(sel); `grant_id`<=sel; `rr_ptr`<=sel; timer<=0; state<=WAIT.
- IDLE, no request: outputs unchanged; `req_ready`=0.
- WAIT:
  - `new_command` is held 1; the timer increments each cycle.
  - `req_valid` is ignored, including the granted requester's bit.
- WAIT, `cmd_complete`=1 on an edge:
  - `new_command`<=0; `done_response`<=`response`; `done_index_error`<=`cmd_index_error`.
  - `done_timeout`<=0; `done_valid`<=onehot(`grant_id`); state<=GAP.
- WAIT, timer==TIMEOUT_CYCLES-1 and `cmd_complete`=0:
  - Same transition, except `done_response`<=0, `done_index_error`<=0, `done_timeout`<=1.
- Simultaneous `cmd_complete` and timeout: completion wins.
- GAP:
  - `new_command`=0 for exactly GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES=0: WAIT exits directly to IDLE.
- `cmd_complete` in IDLE or GAP is ignored; outputs and state are unchanged.
- Round-robin fairness: a requester that holds `req_valid` continuously is granted within NUM_REQ grants.
- `reset_host` asserted mid-command:
  - Immediate return to the reset values; the pending command is discarded.
  - No `done_valid` pulse.
  - `new_command` falls asynchronously.

## Timing
- Grant latency: `req_valid` sampled high in IDLE at edge k → `req_ready` and `new_command` high after edge k; `req_ready` low after edge k+1.
- Completion latency: `cmd_complete` sampled at edge m → `done_valid` high for cycle m..m+1 only; `new_command` low after edge m.
- Timeout: `new_command` high for exactly TIMEOUT_CYCLES cycles, then falls together with the `done_valid` pulse.
- Back-to-back with GAP_CYCLES=G: minimum spacing from `new_command` falling to the next rise is G+1 cycles (G in GAP plus 1 in IDLE).
- `cmd_index`/`cmd_argument` are stable for the whole time `new_command`=1.

## Test plan
- Single request, then completion: req0 index=17, arg=0x0000_002C; `cmd_complete` 5 cycles later with response=128'hA5…A5, error=0. Expect: `req_ready`=3'b001 one cycle; `cmd_index`=17; `new_command` high 5 cycles; `done_valid`=3'b001; response captured; `done_timeout`=0.
- Round-robin: all three `req_valid` held high, each command completing after 3 cycles. Expect grant order 0,1,2,0; `grant_id` sequence 0,1,2,0; every gap between `new_command` pulses = GAP_CYCLES+1 = 9 cycles.
- Timeout: with TIMEOUT_CYCLES=16, a request is never completed. Expect `new_command` high exactly 16 cycles, `done_timeout`=1, `done_response`=0, `done_valid` pulse to the requester.
- Error and race: `cmd_complete`=1 with `cmd_index_error`=1 on the same cycle the timer hits TIMEOUT_CYCLES-1. Expect `done_timeout`=0, `done_index_error`=1.
- Reset mid-WAIT: assert `reset_host` 3 cycles after grant. Expect `new_command`=0 immediately, no `done_valid`, state IDLE; after release, req1 is granted first (`rr_ptr` was reset).
- Stray completion: `cmd_complete` pulses in IDLE and in GAP. Expect no `done_valid`, `done_*` unchanged, no state change.
